hub75_bcm_driver: RTL and testbench
===================================

// Module: hub75_bcm_driver
// PURPOSE
//  Parametrised HUB75 row driver with binary-code-modulated (BCM) colour depth and multiple parallel panel chains.
//  Accepts one scan row per valid/ready transfer: NUM_PIX pixels for the upper half and NUM_PIX for the lower half, per chain.
//  Shifts the row out as BITS bit planes, latches each plane and lights it for BASE_OE<<plane cycles.
//  Sits between frame_manager (source of columns/dtheta) and the panel pins; replaces the single-plane, single-chain output stage.
// PARAMETERS
//  NUM_PIX    64  pixels shifted per half-panel line
//  SCAN_RATE  32  multiplexed row addresses; ADDR_W = $clog2(SCAN_RATE)
//  BITS       3   bits per colour channel; pixel word = {R,G,B}, 3*BITS wide
//  NUM_CHAINS 1   parallel panel chains, each with its own rgb0/rgb1 triplet
//  CLK_DIV    2   led_clk half-period in clk_in cycles (>=1)
//  BASE_OE    8   display cycles for plane 0 (LSB); plane b gets BASE_OE<<b
// PORTS
//  clk_in          in   1                               system clock
//  rst_in          in   1                               async active-high reset
//  pixel_data      in   NUM_CHAINS*2*NUM_PIX*3*BITS     [chain][half][pix][R,G,B]; half 0 = upper (rgb0)
//  address_data    in   ADDR_W                          row address for this transfer
//  tvalid          in   1                               pixel_data/address_data valid
//  tready          out  1                               driver idle, will accept
//  blank_in        in   1                               force panel dark
//  row_done        out  1                               1-cycle pulse after last plane's display ends
//  rgb0            out  3*NUM_CHAINS                    upper-half colour bits, chain c at [3c+2:3c] = {R,G,B}
//  rgb1            out  3*NUM_CHAINS                    lower-half colour bits, same layout
//  led_clk         out  1                               panel shift clock
//  led_latch       out  1                               panel latch, active high
//  led_output_enable out 1                              panel OE, active LOW (1 = dark)
//  hub75_address   out  ADDR_W                          panel row address
// BEHAVIOUR
//  Reset (async, any state):
//   - state=IDLE, plane=0; rgb0/rgb1=0, led_clk=0, led_latch=0, led_output_enable=1, hub75_address=0, row_done=0.
//   - tready=0 while rst_in high.
//   - Captured data is discarded; no partial plane is completed.
//  tready = (state==IDLE) && !rst_in. Transfer on clk edge with tvalid&&tready.
//   - pixel_data and address_data are captured into internal registers on that edge.
//   - Inputs are ignored at all other times.
//  FSM: IDLE -> SHIFT -> LATCH -> SHOW -> (plane<BITS-1 ? SHIFT, plane+1 : IDLE, row_done).
//  SHIFT, per plane b, pixel index p = 0..NUM_PIX-1 in that order:
//   - rgb0/rgb1 = bit b of each R,G,B of pixel p; led_clk low for CLK_DIV cycles, then high for CLK_DIV cycles.
//   - Data is stable the whole low phase; the rising edge is mid-pixel.
//   - 2*CLK_DIV*NUM_PIX cycles per plane; exactly NUM_PIX led_clk rising edges per plane.
//  LATCH:
//   - led_clk=0; 1 gap cycle, then led_latch=1 for CLK_DIV cycles.
//   - hub75_address <= captured address on the first latch cycle.
//   - Total CLK_DIV+1 cycles.
//  SHOW:
//   - led_output_enable = blank_in for exactly BASE_OE<<b cycles; rgb held; led_latch=0.
//   - Counter width $clog2(BASE_OE<<(BITS-1))+1.
//  led_output_enable=1 (dark) in IDLE, SHIFT and LATCH.
//  blank_in:
//   - Combinationally ORed into led_output_enable; asserting it mid-SHOW darkens on the same cycle.
//   - Counters, plane sequencing and row_done timing are unaffected.
//  row_done:
//   - Asserted the cycle state returns to IDLE; tready is high that same cycle.
//   - Back-to-back rows are therefore separated by 0 idle cycles when tvalid is held high.
//  Row period = BITS*(2*CLK_DIV*NUM_PIX + CLK_DIV + 1) + BASE_OE*(2^BITS - 1) cycles, plus 1 accept cycle.
//  address_data of SCAN_RATE-1 followed by 0 needs no special handling (no arithmetic on address).
// TESTING
//  1 Reset values:
//     - Drive rst_in=1 mid-SHIFT with tvalid=1 -> same cycle, all outputs equal reset values and tready=0.
//     - After release, first accept restarts plane 0.
//  2 Plane timing (NUM_PIX=4, BITS=3, CLK_DIV=2, BASE_OE=8, one row):
//     - 12 led_clk rises, 3 latch pulses of 2 cycles.
//     - OE low runs of 8, 16 and 32 cycles; row_done 1 pulse at cycle 3*(16+3)+56+1 = 114.
//  3 Bit-plane data:
//     - Upper pixel 0 R=3'b101, lower pixel 3 B=3'b011.
//     - rgb0[2] sampled at led_clk rise 0 of planes 0,1,2 = 1,0,1.
//     - rgb1[0] at rise 3 = 1,1,0.
//  4 Multi-chain (NUM_CHAINS=2): chain1 all-white, chain0 black -> rgb0[5:3]=3'b111 and rgb0[2:0]=0 on every rise.
//  5 Backpressure:
//     - Second row presented with tvalid held during first row -> tready=0 throughout.
//     - Accepted on the row_done cycle; hub75_address changes only at its first latch.
//  6 blank_in pulsed high for 5 cycles mid plane-2 SHOW -> OE=1 exactly those 5 cycles; row_done cycle unchanged vs. test 2.

Source files
------------

// File: rtl/hub75_bcm_driver.sv
// HUB75 row driver: shifts one captured scan row out as BITS bit planes per chain,
// latching each plane and lighting it for BASE_OE<<plane cycles (binary-code modulation).
module hub75_bcm_driver #(
  parameter int NUM_PIX    = 64,
  parameter int SCAN_RATE  = 32,
  parameter int BITS       = 3,
  parameter int NUM_CHAINS = 1,
  parameter int CLK_DIV    = 2,
  parameter int BASE_OE    = 8,
  parameter int ADDR_W     = $clog2(SCAN_RATE)
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [NUM_CHAINS*2*NUM_PIX*3*BITS-1:0] pixel_data,
  input  logic [ADDR_W-1:0]                    address_data,
  input  logic                                 tvalid,
  output logic                                 tready,
  input  logic                                 blank_in,
  output logic                                 row_done,
  output logic [3*NUM_CHAINS-1:0]              rgb0,
  output logic [3*NUM_CHAINS-1:0]              rgb1,
  output logic                                 led_clk,
  output logic                                 led_latch,
  output logic                                 led_output_enable,
  output logic [ADDR_W-1:0]                    hub75_address,
  output logic [1:0]                           fsm_state
);

  localparam int PIX_W   = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam int PLANE_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int DIV_W   = $clog2(2 * CLK_DIV) + 1;
  localparam int SHOW_W  = $clog2(BASE_OE << (BITS - 1)) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, SHOW} state_t;

  state_t state, state_next;

  // Captured row, indexed [chain][half][pixel][R,G,B][bit]; chain 0 / half 0 / pixel 0 at the LSBs.
  logic [NUM_CHAINS-1:0][1:0][NUM_PIX-1:0][2:0][BITS-1:0] data_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DIV_W-1:0]   div_cnt;
  logic [PIX_W-1:0]   pix;
  logic [PLANE_W-1:0] plane;
  logic [SHOW_W-1:0]  show_cnt;
  logic [SHOW_W-1:0]  show_len;

  logic shift_last, latch_last, show_last, plane_last;

  assign show_len   = SHOW_W'(BASE_OE) << plane;
  assign shift_last = (div_cnt == DIV_W'(2 * CLK_DIV - 1)) && (pix == PIX_W'(NUM_PIX - 1));
  assign latch_last = (div_cnt == DIV_W'(CLK_DIV));
  assign show_last  = (show_cnt == show_len - 1'b1);
  assign plane_last = (plane == PLANE_W'(BITS - 1));

  // Handshake: a row transfers on the clk edge where tvalid && tready; tready is high only
  // in IDLE outside reset, and tvalid/pixel_data/address_data are ignored at all other times.
  assign tready            = (state == IDLE) && !rst_in;
  assign led_clk           = (state == SHIFT) && (div_cnt >= DIV_W'(CLK_DIV));
  assign led_latch         = (state == LATCH) && (div_cnt != '0);
  assign led_output_enable = (state != SHOW) || blank_in;
  assign fsm_state         = state;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tvalid) state_next = SHIFT;
      SHIFT:   if (shift_last) state_next = LATCH;
      LATCH:   if (latch_last) state_next = SHOW;
      SHOW:    if (show_last) state_next = plane_last ? IDLE : SHIFT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_q        <= '0;
      addr_q        <= '0;
      div_cnt       <= '0;
      pix           <= '0;
      plane         <= '0;
      show_cnt      <= '0;
      hub75_address <= '0;
      row_done      <= 1'b0;
    end else begin
      row_done <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt  <= '0;
          pix      <= '0;
          plane    <= '0;
          show_cnt <= '0;
          if (tvalid) begin
            data_q <= pixel_data;
            addr_q <= address_data;
          end
        end
        SHIFT: begin
          // pix holds on the last pixel so rgb stays put through LATCH and SHOW
          if (div_cnt == DIV_W'(2 * CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (!shift_last) pix <= pix + 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        LATCH: begin
          if (div_cnt == '0) hub75_address <= addr_q;
          div_cnt <= latch_last ? '0 : div_cnt + 1'b1;
        end
        SHOW: begin
          if (show_last) begin
            show_cnt <= '0;
            if (plane_last) begin
              row_done <= 1'b1;
            end else begin
              plane <= plane + 1'b1;
              pix   <= '0;
            end
          end else begin
            show_cnt <= show_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_chain
    for (genvar k = 0; k < 3; k++) begin : g_colour
      assign rgb0[3*c+k] = data_q[c][0][pix][k][plane];
      assign rgb1[3*c+k] = data_q[c][1][pix][k][plane];
    end
  end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Bench for hub75_bcm_driver: scoreboarded rgb at every led_clk rise plus timing checks
// on latch pulses, OE runs, row_done cycle, backpressure, blanking and reset.
module tb_hub75_bcm_driver;

  localparam int NUM_PIX    = 4;
  localparam int SCAN_RATE  = 32;
  localparam int BITS       = 3;
  localparam int NUM_CHAINS = 2;
  localparam int CLK_DIV    = 2;
  localparam int BASE_OE    = 8;
  localparam int ADDR_W     = $clog2(SCAN_RATE);
  localparam int WORD_W     = 3 * BITS;
  localparam int PD_W       = NUM_CHAINS * 2 * NUM_PIX * WORD_W;
  localparam int RGB_W      = 3 * NUM_CHAINS;
  localparam int OUT_W      = 2 * RGB_W;
  localparam int ROW_CYCLES = BITS * (2 * CLK_DIV * NUM_PIX + CLK_DIV + 1)
                              + BASE_OE * ((1 << BITS) - 1) + 1;

  // clock / reset
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  logic [PD_W-1:0]   pixel_data = '0;
  logic [ADDR_W-1:0] address_data = '0;
  logic              tvalid = 1'b0;
  logic              blank_in = 1'b0;
  logic              tready, row_done, led_clk, led_latch, led_output_enable;
  logic [RGB_W-1:0]  rgb0, rgb1;
  logic [ADDR_W-1:0] hub75_address;
  logic [1:0]        fsm_state;

  hub75_bcm_driver #(
    .NUM_PIX(NUM_PIX), .SCAN_RATE(SCAN_RATE), .BITS(BITS),
    .NUM_CHAINS(NUM_CHAINS), .CLK_DIV(CLK_DIV), .BASE_OE(BASE_OE)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .pixel_data(pixel_data),
    .address_data(address_data), .tvalid(tvalid), .tready(tready),
    .blank_in(blank_in), .row_done(row_done), .rgb0(rgb0), .rgb1(rgb1),
    .led_clk(led_clk), .led_latch(led_latch),
    .led_output_enable(led_output_enable), .hub75_address(hub75_address),
    .fsm_state(fsm_state)
  );

  // scoreboard and monitor state
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] rise_log[$];
  int               oe_runs[$];
  logic [OUT_W-1:0] mon_exp;
  logic [WORD_W-1:0] px [NUM_CHAINS][2][NUM_PIX];
  int checks = 0, failures = 0;
  int rise_cnt = 0, latch_pulses = 0, done_cnt = 0, done_cyc = -1;
  int acc_cyc = 0, oe_run = 0, latch_run = 0;
  logic prev_led_clk = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  always @(negedge clk_in) begin
    if (rst_in) begin
      prev_led_clk = 1'b0;
      oe_run       = 0;
      latch_run    = 0;
      acc_cyc      = 0;
      prev_addr    = hub75_address;
    end else begin
      acc_cyc++;
      if (led_clk && !prev_led_clk) begin
        rise_cnt++;
        rise_log.push_back({rgb1, rgb0});
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_empty: led_clk rise with no expected data, got rgb=%h", {rgb1, rgb0});
        end else begin
          mon_exp = exp_q.pop_front();
          if ({rgb1, rgb0} !== mon_exp) begin
            failures++;
            $display("FAIL scoreboard_rgb: rise %0d got {rgb1,rgb0}=%h expected %h", rise_cnt - 1, {rgb1, rgb0}, mon_exp);
          end
        end
      end
      prev_led_clk = led_clk;
      if (hub75_address !== prev_addr) begin
        checks++;
        if (!(led_latch && latch_run == 0)) begin
          failures++;
          $display("FAIL addr_timing: hub75_address changed to %0d with led_latch=%b latch_run=%0d, required first latch cycle",
                   hub75_address, led_latch, latch_run);
        end
        prev_addr = hub75_address;
      end
      if (led_latch) latch_run++;
      else if (latch_run > 0) begin
        checks++;
        if (latch_run != CLK_DIV) begin
          failures++;
          $display("FAIL latch_len: latch pulse %0d cycles, expected %0d", latch_run, CLK_DIV);
        end
        latch_pulses++;
        latch_run = 0;
      end
      if (!led_output_enable) oe_run++;
      else if (oe_run > 0) begin
        oe_runs.push_back(oe_run);
        oe_run = 0;
      end
      if (row_done) begin
        done_cnt++;
        done_cyc = acc_cyc;
      end
      if (tvalid && tready) acc_cyc = 0;
    end
  end

  // driver tasks
  task automatic fill_random();
    for (int c = 0; c < NUM_CHAINS; c++)
      for (int h = 0; h < 2; h++)
        for (int p = 0; p < NUM_PIX; p++)
          px[c][h][p] = WORD_W'($urandom_range(0, (1 << WORD_W) - 1));
  endtask

  task automatic load_row(input logic [ADDR_W-1:0] addr);
    logic [PD_W-1:0]  flat;
    logic [OUT_W-1:0] e;
    flat = '0;
    for (int c = 0; c < NUM_CHAINS; c++)
      for (int h = 0; h < 2; h++)
        for (int p = 0; p < NUM_PIX; p++)
          flat[((c*2+h)*NUM_PIX+p)*WORD_W +: WORD_W] = px[c][h][p];
    pixel_data   = flat;
    address_data = addr;
    for (int b = 0; b < BITS; b++)
      for (int p = 0; p < NUM_PIX; p++) begin
        e = '0;
        for (int c = 0; c < NUM_CHAINS; c++)
          for (int h = 0; h < 2; h++)
            for (int k = 0; k < 3; k++)
              e[h*RGB_W + 3*c + k] = px[c][h][p][k*BITS + b];
        exp_q.push_back(e);
      end
  endtask

  task automatic handshake(input string name);
    bit ok = 0;
    tvalid = 1'b1;
    for (int i = 0; i < 4 * ROW_CYCLES; i++) begin
      @(negedge clk_in);
      if (tready) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_accept: tready never high within %0d cycles", name, 4 * ROW_CYCLES);
    end
    @(posedge clk_in); #1;
    tvalid = 1'b0;
  endtask

  task automatic send_row(input logic [ADDR_W-1:0] addr, input string name);
    load_row(addr);
    handshake(name);
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 4 * ROW_CYCLES; i++) begin
      @(negedge clk_in);
      if (row_done) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_done_timeout: row_done not seen within %0d cycles", name, 4 * ROW_CYCLES);
    end
    @(posedge clk_in); #1;
  endtask

  task automatic clear_stats();
    rise_cnt = 0; latch_pulses = 0; done_cnt = 0; done_cyc = -1;
    oe_runs.delete();
    rise_log.delete();
  endtask

  task automatic test_reset();
    logic [2*RGB_W+ADDR_W+7:0] got, req;
    req = {{(2*RGB_W){1'b0}}, 1'b0, 1'b0, 1'b1, {ADDR_W{1'b0}}, 1'b0, 1'b0, 2'b00};
    #1;
    got = {rgb0, rgb1, led_clk, led_latch, led_output_enable, hub75_address, row_done, tready, fsm_state};
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL reset_initial: outputs %h expected %h", got, req);
    end
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    clear_stats();
    fill_random();
    send_row(ADDR_W'(7), "reset_row1");
    wait_done("reset_row1");
    checks++;
    if (hub75_address !== ADDR_W'(7)) begin
      failures++;
      $display("FAIL reset_row1_addr: hub75_address=%0d expected 7", hub75_address);
    end
    // second row all-ones, reset lands mid-SHIFT with led_clk high
    for (int c = 0; c < NUM_CHAINS; c++)
      for (int h = 0; h < 2; h++)
        for (int p = 0; p < NUM_PIX; p++) px[c][h][p] = '1;
    send_row(ADDR_W'(12), "reset_row2");
    repeat (6) @(posedge clk_in);
    #1;
    exp_q.delete();
    fill_random();
    load_row(ADDR_W'(3));
    tvalid = 1'b1;
    rst_in = 1'b1;
    #1;
    got = {rgb0, rgb1, led_clk, led_latch, led_output_enable, hub75_address, row_done, tready, fsm_state};
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL reset_mid_shift: outputs %h expected %h", got, req);
    end
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    clear_stats();
    handshake("reset_restart");
    wait_done("reset_restart");
    checks++;
    if (done_cyc != ROW_CYCLES) begin
      failures++;
      $display("FAIL reset_restart_done_cycle: row_done at %0d expected %0d", done_cyc, ROW_CYCLES);
    end
    checks++;
    if (hub75_address !== ADDR_W'(3)) begin
      failures++;
      $display("FAIL reset_restart_addr: hub75_address=%0d expected 3", hub75_address);
    end
  endtask

  task automatic test_plane_timing();
    clear_stats();
    fill_random();
    send_row(ADDR_W'(10), "timing");
    wait_done("timing");
    checks++;
    if (rise_cnt != NUM_PIX * BITS) begin
      failures++;
      $display("FAIL timing_rises: %0d led_clk rises expected %0d", rise_cnt, NUM_PIX * BITS);
    end
    checks++;
    if (latch_pulses != BITS) begin
      failures++;
      $display("FAIL timing_latches: %0d latch pulses expected %0d", latch_pulses, BITS);
    end
    checks++;
    if (oe_runs.size() != BITS) begin
      failures++;
      $display("FAIL timing_oe_count: %0d OE low runs expected %0d", oe_runs.size(), BITS);
    end else begin
      for (int b = 0; b < BITS; b++) begin
        checks++;
        if (oe_runs[b] != (BASE_OE << b)) begin
          failures++;
          $display("FAIL timing_oe_len: plane %0d OE low %0d cycles expected %0d", b, oe_runs[b], BASE_OE << b);
        end
      end
    end
    checks++;
    if (done_cyc != ROW_CYCLES || done_cnt != 1) begin
      failures++;
      $display("FAIL timing_row_done: cycle %0d count %0d expected cycle %0d count 1", done_cyc, done_cnt, ROW_CYCLES);
    end
    checks++;
    if (row_done !== 1'b0 || tready !== 1'b1) begin
      failures++;
      $display("FAIL timing_after_done: row_done=%b tready=%b expected 0 and 1", row_done, tready);
    end
  endtask

  task automatic test_bit_planes();
    logic [2:0] r_exp, b_exp;
    r_exp = 3'b101;
    b_exp = 3'b011;
    clear_stats();
    fill_random();
    px[0][0][0][2*BITS +: BITS] = 3'b101;
    px[0][1][3][0 +: BITS]      = 3'b011;
    send_row(ADDR_W'(31), "planes");
    wait_done("planes");
    checks++;
    if (rise_log.size() != NUM_PIX * BITS) begin
      failures++;
      $display("FAIL planes_log: %0d rises logged expected %0d", rise_log.size(), NUM_PIX * BITS);
    end else begin
      for (int b = 0; b < BITS; b++) begin
        checks++;
        if (rise_log[b*NUM_PIX][2] !== r_exp[b]) begin
          failures++;
          $display("FAIL planes_rgb0_r: plane %0d rise 0 rgb0[2]=%b expected %b", b, rise_log[b*NUM_PIX][2], r_exp[b]);
        end
        checks++;
        if (rise_log[b*NUM_PIX+3][RGB_W] !== b_exp[b]) begin
          failures++;
          $display("FAIL planes_rgb1_b: plane %0d rise 3 rgb1[0]=%b expected %b", b, rise_log[b*NUM_PIX+3][RGB_W], b_exp[b]);
        end
      end
    end
  endtask

  task automatic test_multi_chain();
    logic [RGB_W-1:0] want;
    want = {3'b111, 3'b000};
    clear_stats();
    for (int h = 0; h < 2; h++)
      for (int p = 0; p < NUM_PIX; p++) begin
        px[0][h][p] = '0;
        px[1][h][p] = '1;
      end
    send_row(ADDR_W'(0), "chain");
    wait_done("chain");
    checks++;
    if (rise_log.size() != NUM_PIX * BITS) begin
      failures++;
      $display("FAIL chain_log: %0d rises logged expected %0d", rise_log.size(), NUM_PIX * BITS);
    end
    for (int i = 0; i < rise_log.size(); i++) begin
      checks++;
      if (rise_log[i] !== {want, want}) begin
        failures++;
        $display("FAIL chain_rgb: rise %0d {rgb1,rgb0}=%h expected %h", i, rise_log[i], {want, want});
      end
    end
  endtask

  task automatic test_back_to_back();
    int  tready_hi = 0;
    bit  seen = 0;
    clear_stats();
    fill_random();
    send_row(ADDR_W'(5), "b2b_first");
    fill_random();
    load_row(ADDR_W'(9));
    tvalid = 1'b1;
    for (int i = 0; i < 4 * ROW_CYCLES; i++) begin
      @(negedge clk_in);
      if (row_done) begin seen = 1; break; end
      if (tready !== 1'b0) tready_hi++;
    end
    checks++;
    if (!seen || tready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept: row_done seen=%0d tready=%b expected 1 and 1", seen, tready);
    end
    checks++;
    if (tready_hi != 0) begin
      failures++;
      $display("FAIL b2b_backpressure: tready high %0d cycles during busy row, expected 0", tready_hi);
    end
    @(posedge clk_in); #1;
    tvalid = 1'b0;
    checks++;
    if (hub75_address !== ADDR_W'(5)) begin
      failures++;
      $display("FAIL b2b_addr_hold: hub75_address=%0d expected 5 before first latch", hub75_address);
    end
    wait_done("b2b_second");
    checks++;
    if (done_cyc != ROW_CYCLES || done_cnt != 2 || rise_cnt != 2 * NUM_PIX * BITS) begin
      failures++;
      $display("FAIL b2b_second_row: done cycle %0d count %0d rises %0d expected %0d 2 %0d",
               done_cyc, done_cnt, rise_cnt, ROW_CYCLES, 2 * NUM_PIX * BITS);
    end
    checks++;
    if (hub75_address !== ADDR_W'(9)) begin
      failures++;
      $display("FAIL b2b_addr: hub75_address=%0d expected 9", hub75_address);
    end
  endtask

  task automatic test_blank();
    int want [4];
    want = '{8, 16, 8, 19};
    clear_stats();
    fill_random();
    send_row(ADDR_W'(6), "blank");
    repeat (89) @(posedge clk_in);
    #1 blank_in = 1'b1;
    repeat (5) @(posedge clk_in);
    #1 blank_in = 1'b0;
    wait_done("blank");
    checks++;
    if (oe_runs.size() != 4) begin
      failures++;
      $display("FAIL blank_oe_count: %0d OE low runs expected 4", oe_runs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (oe_runs[i] != want[i]) begin
          failures++;
          $display("FAIL blank_oe_len: run %0d is %0d cycles expected %0d", i, oe_runs[i], want[i]);
        end
      end
    end
    checks++;
    if (done_cyc != ROW_CYCLES) begin
      failures++;
      $display("FAIL blank_row_done: row_done at %0d expected %0d", done_cyc, ROW_CYCLES);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_plane_timing();
    test_bit_planes();
    test_multi_chain();
    test_back_to_back();
    test_blank();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: %0d expected entries never produced", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
